// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS-subset core with host-loadable 128-word instruction and data memories.
// Executes one instruction per clock edge while writeEnable is low, and is halted for loading while it is high.
module mips_single_cycle_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [6:0]  instructionAddress,
  input  logic [31:0] data,
  input  logic [6:0]  dataAddress,
  input  logic        writeEnable,
  input  logic [4:0]  dbgRegSel,
  output logic [31:0] dbgRegValue,
  output logic [6:0]  pc
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int NREGS  = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic        [ADDR_W-1:0] pc_q, pc_d;
  logic signed [DATA_W-1:0] rf_q   [NREGS];
  logic        [DATA_W-1:0] imem_q [DEPTH];
  logic        [DATA_W-1:0] dmem_q [DEPTH];

  logic                     rf_we_d;
  logic        [4:0]        rf_waddr_d;
  logic signed [DATA_W-1:0] rf_wdata_d;
  logic                     imem_we_d;
  logic        [ADDR_W-1:0] imem_addr_d;
  logic        [DATA_W-1:0] imem_wdata_d;
  logic                     dmem_we_d;
  logic        [ADDR_W-1:0] dmem_addr_d;
  logic        [DATA_W-1:0] dmem_wdata_d;

  logic        [DATA_W-1:0] instr;
  logic        [5:0]        opcode;
  logic        [4:0]        rs, rt, rd;
  logic        [5:0]        funct;
  logic signed [DATA_W-1:0] simm;
  logic signed [DATA_W-1:0] rs_val, rt_val;
  logic signed [DATA_W-1:0] addr_sum;
  logic        [ADDR_W-1:0] ea;
  logic        [DATA_W-1:0] dmem_rdata;
  logic                     funct_ok;
  logic        [4:0]        unused_shamt;

  function automatic logic signed [DATA_W-1:0] alu_r(
    input logic        [5:0]        fn,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] res;
    res = '0;
    case (fn)
      FN_ADD:  res = a + b;
      FN_SUB:  res = a - b;
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_SLT:  res = (a < b) ? DATA_W'(1) : '0;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic is_known_funct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // Fetch and decode
  assign instr        = imem_q[pc_q];
  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = instr[10:6];
  assign funct        = instr[5:0];
  assign simm         = {{16{instr[15]}}, instr[15:0]};
  assign funct_ok     = is_known_funct(funct);

  // Register 0 is never written, but force it anyway so reads are robust.
  assign rs_val     = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val     = (rt == 5'd0) ? '0 : rf_q[rt];
  assign addr_sum   = rs_val + simm;
  assign ea         = addr_sum[ADDR_W-1:0];
  assign dmem_rdata = dmem_q[ea];

  always_comb begin
    pc_d         = pc_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rt;
    rf_wdata_d   = '0;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = ea;
    dmem_wdata_d = rt_val;
    imem_we_d    = 1'b0;
    imem_addr_d  = instructionAddress;
    imem_wdata_d = instruction;

    if (writeEnable) begin
      imem_we_d    = 1'b1;
      dmem_we_d    = 1'b1;
      dmem_addr_d  = dataAddress;
      dmem_wdata_d = data;
    end else begin
      pc_d = pc_q + ADDR_W'(1);
      case (opcode)
        OP_RTYPE: begin
          if (funct_ok) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = alu_r(funct, rs_val, rt_val);
          end
        end
        OP_ADDI: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = addr_sum;
        end
        OP_LW: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = dmem_rdata;
        end
        OP_SW: begin
          dmem_we_d = 1'b1;
        end
        OP_BEQ: begin
          if (rs_val == rt_val) begin
            pc_d = pc_q + ADDR_W'(1) + simm[ADDR_W-1:0];
          end
        end
        OP_J: begin
          pc_d = instr[ADDR_W-1:0];
        end
        default: ;
      endcase
      if (rf_waddr_d == 5'd0) begin
        rf_we_d = 1'b0;
      end
    end
  end

  // Architectural state commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (rf_we_d) begin
        rf_q[rf_waddr_d] <= rf_wdata_d;
      end
    end
  end

  // Memories keep their contents through reset; writes are simply blocked while it is held.
  always_ff @(posedge clk) begin
    if (rst_n && imem_we_d) begin
      imem_q[imem_addr_d] <= imem_wdata_d;
    end
    if (rst_n && dmem_we_d) begin
      dmem_q[dmem_addr_d] <= dmem_wdata_d;
    end
  end

  assign pc          = pc_q;
  assign dbgRegValue = (dbgRegSel == 5'd0) ? '0 : rf_q[dbgRegSel];

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: loads a program from a vector table, steps it against a scoreboard,
// then walks through hold, asynchronous reset and reset-during-load sequences.
`timescale 1ns/100ps
module tb_mips_single_cycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [6:0]  instructionAddress;
  logic [31:0] data;
  logic [6:0]  dataAddress;
  logic        writeEnable;
  logic [4:0]  dbgRegSel;
  logic [31:0] dbgRegValue;
  logic [6:0]  pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] instr;
    logic [4:0]  sel;
    logic [31:0] val;
    logic [6:0]  pc_next;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [31:0] val;
    logic [6:0]  pc;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];

  mips_single_cycle_core dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instruction        (instruction),
    .instructionAddress (instructionAddress),
    .data               (data),
    .dataAddress        (dataAddress),
    .writeEnable        (writeEnable),
    .dbgRegSel          (dbgRegSel),
    .dbgRegValue        (dbgRegValue),
    .pc                 (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input logic [6:0] ia, input logic [31:0] iw,
                      input logic [6:0] da, input logic [31:0] dw);
    writeEnable        = 1'b1;
    instructionAddress = ia;
    instruction        = iw;
    dataAddress        = da;
    data               = dw;
    @(posedge clk);
    #1;
  endtask

  // One run-mode edge: expectation goes in before the edge, comes out after it.
  task automatic step(input string name, input logic [4:0] sel,
                      input logic [31:0] val, input logic [6:0] pc_exp);
    exp_t e;
    writeEnable = 1'b0;
    dbgRegSel   = sel;
    sb.push_back('{name, sel, val, pc_exp});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      dbgRegSel = e.sel;
      #1;
      check({e.name, "_pc"},  {25'd0, pc}, {25'd0, e.pc});
      check({e.name, "_reg"}, dbgRegValue, e.val);
    end
  endtask

  initial begin
    vecs[0]  = '{7'd0,   32'h20010003, 5'd1,  32'd3,        7'd1};
    vecs[1]  = '{7'd1,   32'hAC010000, 5'd1,  32'd3,        7'd2};
    vecs[2]  = '{7'd2,   32'h8C020005, 5'd2,  32'd12,       7'd3};
    vecs[3]  = '{7'd3,   32'h00421820, 5'd3,  32'd24,       7'd4};
    vecs[4]  = '{7'd4,   32'h10000002, 5'd3,  32'd24,       7'd7};
    vecs[5]  = '{7'd7,   32'h00622022, 5'd4,  32'd12,       7'd8};
    vecs[6]  = '{7'd8,   32'h0083282A, 5'd5,  32'd1,        7'd9};
    vecs[7]  = '{7'd9,   32'h8C060000, 5'd6,  32'd3,        7'd10};
    vecs[8]  = '{7'd10,  32'h10220005, 5'd2,  32'd12,       7'd11};
    vecs[9]  = '{7'd11,  32'h20000005, 5'd0,  32'd0,        7'd12};
    vecs[10] = '{7'd12,  32'hFC000000, 5'd1,  32'd3,        7'd13};
    vecs[11] = '{7'd13,  32'h00433824, 5'd7,  32'd8,        7'd14};
    vecs[12] = '{7'd14,  32'h00434025, 5'd8,  32'd28,       7'd15};
    vecs[13] = '{7'd15,  32'h08000010, 5'd8,  32'd28,       7'd16};
    vecs[14] = '{7'd16,  32'h200AFFFF, 5'd10, 32'hFFFFFFFF, 7'd17};
    vecs[15] = '{7'd17,  32'h0140482A, 5'd9,  32'd1,        7'd18};
    vecs[16] = '{7'd18,  32'h0800007F, 5'd9,  32'd1,        7'd127};
    vecs[17] = '{7'd127, 32'h00000000, 5'd5,  32'd1,        7'd0};
    vecs[18] = '{7'd0,   32'h20010003, 5'd1,  32'd3,        7'd1};
    vecs[19] = '{7'd1,   32'hAC010000, 5'd1,  32'd3,        7'd2};

    rst_n              = 1'b0;
    writeEnable        = 1'b1;
    instruction        = '0;
    instructionAddress = '0;
    data               = '0;
    dataAddress        = '0;
    dbgRegSel          = 5'd1;
    #2;
    check("reset_pc", {25'd0, pc}, 32'd0);
    check("reset_r1", dbgRegValue, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    load(7'd0, 32'hFC000000, 7'd0, 32'd12);
    load(7'd1, 32'hFC000000, 7'd5, 32'd12);
    for (int i = 0; i < 18; i++) begin
      load(vecs[i].addr, vecs[i].instr, 7'd100, 32'd0);
    end
    check("load_pc_held", {25'd0, pc}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].sel, vecs[i].val, vecs[i].pc_next);
    end

    // Hold in load mode for 10 edges; also plant addi r13,r0,7 at imem[1].
    for (int i = 0; i < 10; i++) begin
      load(7'd1, 32'h200D0007, 7'd100, 32'd0);
    end
    check("hold_pc", {25'd0, pc}, 32'd0);
    dbgRegSel = 5'd3; #1;
    check("hold_r3", dbgRegValue, 32'd24);
    dbgRegSel = 5'd9; #1;
    check("hold_r9", dbgRegValue, 32'd1);

    step("resume_addi", 5'd1,  32'd3, 7'd1);
    step("fresh_load",  5'd13, 32'd7, 7'd2);

    // Asynchronous reset mid-cycle, checked before the next edge.
    rst_n = 1'b0;
    #0.5;
    check("async_pc", {25'd0, pc}, 32'd0);
    begin
      int nz;
      nz = 0;
      for (int r = 0; r < 32; r++) begin
        dbgRegSel = r[4:0];
        #0.1;
        if (dbgRegValue !== 32'd0) nz++;
      end
      check("async_regs_nonzero", nz, 32'd0);
    end

    // Load attempt while reset is held must not reach memory.
    writeEnable        = 1'b1;
    instructionAddress = 7'd0;
    instruction        = 32'hFC000000;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    rst_n       = 1'b1;
    #1;
    check("post_reset_pc", {25'd0, pc}, 32'd0);
    step("after_reset_addi", 5'd1, 32'd3, 7'd1);
    step("after_reset_r13",  5'd13, 32'd7, 7'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
